// File: rtl/block_lookup_arbiter_pkg.sv
// Shared game constants: map geometry, coordinate/address widths and requester indices.
// Also provides the map coordinate to collision-RAM address helper.
package game_pkg;

    localparam int unsigned MAP_W   = 960;
    localparam int unsigned MAP_H   = 500;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned ADDR_W  = 20;

    localparam int unsigned REQ_CHAR   = 0;
    localparam int unsigned REQ_ENEMY0 = 1;
    localparam int unsigned REQ_ENEMY1 = 2;
    localparam int unsigned REQ_FIRE   = 3;

    // Row-major linear address; both coordinates are zero-extended before the multiply-add.
    function automatic logic [ADDR_W-1:0] xy_to_addr(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y
    );
        return ADDR_W'(x) + ADDR_W'(y) * ADDR_W'(MAP_W);
    endfunction

endpackage

// File: rtl/block_lookup_arbiter_rr_arbiter.sv
// Round-robin one-hot arbiter: the search starts at the pointer and wraps;
// the pointer moves past the winner and holds when nothing is granted.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;

    always_comb begin
        int unsigned idx;
        idx      = 0;
        grant    = '0;
        ptr_next = ptr;
        // Grant is suppressed during reset so req_ready reads 0 while RST is high.
        if (!rst) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                idx = (32'(ptr) + off) % NUM_REQ;
                if ((grant == '0) && req[idx]) begin
                    grant[idx] = 1'b1;
                    ptr_next   = PTR_W'((idx + 1) % NUM_REQ);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/block_lookup_arbiter.sv
// Shares the single-port collision RAM between sprite requesters: round-robin grant,
// coordinate-to-address issue, and tag delay line routing the block flag back.
module block_lookup_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAP_W      = game_pkg::MAP_W,
    parameter int unsigned MAP_H      = game_pkg::MAP_H,
    parameter int unsigned COORD_W    = game_pkg::COORD_W,
    parameter int unsigned ADDR_W     = game_pkg::ADDR_W,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                       sys_clk,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic                       rsp_block,
    output logic                       ram_en,
    output logic [ADDR_W-1:0]          ram_addr,
    input  logic                       ram_dout
);

    logic [NUM_REQ-1:0] grant;
    logic               granted;
    logic [COORD_W-1:0] x_sel;
    logic [COORD_W-1:0] y_sel;
    logic               oob;
    logic [ADDR_W-1:0]  addr;

    // Entry 0 lines up with the issue cycle; entry RD_LATENCY with the cycle ram_dout is valid.
    logic [RD_LATENCY:0][NUM_REQ-1:0] tag_pipe;
    logic [RD_LATENCY:0]              oob_pipe;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .clk  (sys_clk),
        .rst  (RST),
        .req  (req_valid),
        .grant(grant)
    );

    assign req_ready = grant;
    assign granted   = |grant;

    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                x_sel = req_x[i*COORD_W +: COORD_W];
                y_sel = req_y[i*COORD_W +: COORD_W];
            end
        end
    end

    assign oob  = (32'(x_sel) >= MAP_W) || (32'(y_sel) >= MAP_H);
    assign addr = ADDR_W'(x_sel) + ADDR_W'(y_sel) * ADDR_W'(MAP_W);

    always_ff @(posedge sys_clk) begin
        if (RST) begin
            ram_en    <= 1'b0;
            ram_addr  <= '0;
            tag_pipe  <= '0;
            oob_pipe  <= '0;
            rsp_valid <= '0;
            rsp_block <= 1'b0;
        end else begin
            ram_en      <= granted && !oob;
            ram_addr    <= (granted && !oob) ? addr : '0;
            tag_pipe[0] <= grant;
            oob_pipe[0] <= granted && oob;
            for (int unsigned k = 1; k <= RD_LATENCY; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
                oob_pipe[k] <= oob_pipe[k-1];
            end
            // Out-of-map lookups read as solid so map edges behave as walls.
            rsp_valid <= tag_pipe[RD_LATENCY];
            rsp_block <= (|tag_pipe[RD_LATENCY]) && (oob_pipe[RD_LATENCY] || ram_dout);
        end
    end

endmodule

// File: tb/tb_block_lookup_arbiter.sv
// Self-checking bench for block_lookup_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a queue-based lookup model.
module tb_block_lookup_arbiter;
    import game_pkg::*;

    logic        sys_clk = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [39:0] req_x = '0;
    logic [39:0] req_y = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic        rsp_block;
    logic        ram_en;
    logic [19:0] ram_addr;
    logic        ram_dout = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    block_lookup_arbiter #(
        .NUM_REQ(4), .MAP_W(960), .MAP_H(500), .COORD_W(10), .ADDR_W(20), .RD_LATENCY(1)
    ) dut (
        .sys_clk(sys_clk), .RST(RST), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_block(rsp_block),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout)
    );

    // Collision RAM contents: explicit programmed bits, otherwise a fixed address pattern.
    bit mem[int unsigned];

    function automatic bit mem_bit(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return bit'((a ^ (a >> 5) ^ (a >> 11)) & 1);
    endfunction

    always @(posedge sys_clk) begin
        if (ram_en === 1'b1) ram_dout <= mem_bit(32'(ram_addr));
        else ram_dout <= 1'b0;
    end

    // Lookup model: each accepted lookup is a record with its issue and response cycles.
    typedef struct {
        int          tag;
        bit          oob;
        int unsigned addr;
        longint      issue;
        longint      done;
    } ent_t;

    ent_t   pend[$];
    int     ptr = 0;
    longint cyc = 0;

    bit          cur_rst;
    bit [3:0]    cur_v;
    int unsigned cur_x[4];
    int unsigned cur_y[4];

    logic [3:0]  obs_ready;
    logic [3:0]  obs_rsp;
    logic        obs_blk;
    logic        obs_en;
    logic [19:0] obs_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic run_cycle();
        bit [3:0]    eg;
        bit          een;
        int unsigned eaddr;
        bit [3:0]    ersp;
        bit          eblk;
        int          g;
        RST       = cur_rst;
        req_valid = cur_v;
        for (int i = 0; i < 4; i++) begin
            req_x[i*10 +: 10] = 10'(cur_x[i]);
            req_y[i*10 +: 10] = 10'(cur_y[i]);
        end
        #3;
        eg = '0;
        g  = -1;
        if (!cur_rst) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (ptr + k) % 4;
                if (g < 0 && cur_v[idx]) g = idx;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        een = 0; eaddr = 0; ersp = '0; eblk = 0;
        foreach (pend[j]) begin
            if (pend[j].issue == cyc && !pend[j].oob) begin
                een   = 1'b1;
                eaddr = pend[j].addr;
            end
            if (pend[j].done == cyc) begin
                ersp[pend[j].tag] = 1'b1;
                eblk = pend[j].oob ? 1'b1 : mem_bit(pend[j].addr);
            end
        end
        obs_ready = req_ready;
        obs_rsp   = rsp_valid;
        obs_blk   = rsp_block;
        obs_en    = ram_en;
        obs_addr  = ram_addr;
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("ram_en", 32'(ram_en), 32'(een));
        chk("ram_addr", 32'(ram_addr), eaddr);
        chk("rsp_valid", 32'(rsp_valid), 32'(ersp));
        if (ersp != '0) chk("rsp_block", 32'(rsp_block), 32'(eblk));
        chk("rsp_onehot", 32'($onehot0(rsp_valid)), 32'd1);
        @(posedge sys_clk);
        #1;
        if (cur_rst) begin
            pend.delete();
            ptr = 0;
        end else if (g >= 0) begin
            ent_t e;
            e.tag   = g;
            e.oob   = (cur_x[g] >= 960) || (cur_y[g] >= 500);
            e.addr  = e.oob ? 0 : cur_x[g] + cur_y[g] * 960;
            e.issue = cyc + 1;
            e.done  = cyc + 3;
            pend.push_back(e);
            ptr = (g + 1) % 4;
        end
        while (pend.size() > 0 && pend[0].done <= cyc) void'(pend.pop_front());
        cyc++;
    endtask

    task automatic set_all(input bit r, input bit [3:0] v, input int unsigned x, input int unsigned y);
        cur_rst = r;
        cur_v   = v;
        for (int i = 0; i < 4; i++) begin
            cur_x[i] = x;
            cur_y[i] = y;
        end
    endtask

    typedef struct {
        bit          rst;
        bit [3:0]    v;
        int unsigned x;
        int unsigned y;
        bit [3:0]    ready;
        bit          en;
        int unsigned addr;
        bit [3:0]    rsp;
        bit          blk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit r, input bit [3:0] v, input int unsigned x, input int unsigned y,
                                input bit [3:0] rdy, input bit en, input int unsigned a,
                                input bit [3:0] rsp, input bit blk);
        vec_t t;
        t.rst = r; t.v = v; t.x = x; t.y = y; t.ready = rdy; t.en = en; t.addr = a; t.rsp = rsp; t.blk = blk;
        return t;
    endfunction

    initial begin
        bit [3:0] bits;
        int       since2;
        mem[345820] = 1'b1;
        mem[479999] = 1'b0;
        mem[1925]   = 1'b0;
        bits = 4'b1101;
        for (int k = 0; k < 4; k++) mem[100 + (10 + k) * 960] = bits[k];

        // Single request, bounds, then four-way contention after a fresh reset.
        tbl.push_back(mk(1, 4'b1111, 220, 360, 4'b0000, 0, 0,      4'b0000, 0));
        tbl.push_back(mk(0, 4'b0001, 220, 360, 4'b0001, 0, 0,      4'b0000, 0));
        tbl.push_back(mk(0, 4'b0000, 0,   0,   4'b0000, 1, 345820, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b0000, 0,   0,   4'b0000, 0, 0,      4'b0000, 0));
        tbl.push_back(mk(0, 4'b0000, 0,   0,   4'b0000, 0, 0,      4'b0001, 1));
        tbl.push_back(mk(0, 4'b0001, 960, 0,   4'b0001, 0, 0,      4'b0000, 0));
        tbl.push_back(mk(0, 4'b0001, 959, 499, 4'b0001, 0, 0,      4'b0000, 0));
        tbl.push_back(mk(0, 4'b0000, 0,   0,   4'b0000, 1, 479999, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b0000, 0,   0,   4'b0000, 0, 0,      4'b0001, 1));
        tbl.push_back(mk(0, 4'b0000, 0,   0,   4'b0000, 0, 0,      4'b0001, 0));
        tbl.push_back(mk(1, 4'b0000, 0,   0,   4'b0000, 0, 0,      4'b0000, 0));
        tbl.push_back(mk(0, 4'b1111, 5,   2,   4'b0001, 0, 0,      4'b0000, 0));
        tbl.push_back(mk(0, 4'b1111, 5,   2,   4'b0010, 1, 1925,   4'b0000, 0));
        tbl.push_back(mk(0, 4'b1111, 5,   2,   4'b0100, 1, 1925,   4'b0000, 0));
        tbl.push_back(mk(0, 4'b1111, 5,   2,   4'b1000, 1, 1925,   4'b0001, 0));
        tbl.push_back(mk(0, 4'b0000, 0,   0,   4'b0000, 1, 1925,   4'b0010, 0));
        tbl.push_back(mk(0, 4'b0000, 0,   0,   4'b0000, 0, 0,      4'b0100, 0));
        tbl.push_back(mk(0, 4'b0000, 0,   0,   4'b0000, 0, 0,      4'b1000, 0));
        tbl.push_back(mk(0, 4'b0000, 0,   0,   4'b0000, 0, 0,      4'b0000, 0));

        // Power-up reset: outputs are unknown until this edge, so nothing is compared.
        set_all(1, 4'b0000, 0, 0);
        RST = 1'b1;
        req_valid = '0;
        @(posedge sys_clk);
        #1;

        foreach (tbl[n]) begin
            set_all(tbl[n].rst, tbl[n].v, tbl[n].x, tbl[n].y);
            run_cycle();
            chk("tbl_ready", 32'(obs_ready), 32'(tbl[n].ready));
            chk("tbl_ram_en", 32'(obs_en), 32'(tbl[n].en));
            chk("tbl_ram_addr", 32'(obs_addr), tbl[n].addr);
            chk("tbl_rsp_valid", 32'(obs_rsp), 32'(tbl[n].rsp));
            if (tbl[n].rsp != '0) chk("tbl_rsp_block", 32'(obs_blk), 32'(tbl[n].blk));
        end

        // Fairness: req0 and req2 held permanently alternate, req2 never waits over 2 cycles.
        set_all(1, 4'b0000, 0, 0);
        run_cycle();
        since2 = 0;
        for (int k = 0; k < 12; k++) begin
            set_all(0, 4'b0101, 30 + k, 7);
            run_cycle();
            chk("fair_grant", 32'(obs_ready), (k % 2 == 0) ? 32'h1 : 32'h4);
            since2 = obs_ready[2] ? 0 : since2 + 1;
            chk("fair_starve", 32'(since2 <= 2), 32'd1);
        end

        // Reset mid-flight: two lookups in flight are discarded and the pointer returns to 0.
        set_all(1, 4'b0000, 0, 0);
        run_cycle();
        set_all(0, 4'b0100, 10, 10);
        run_cycle();
        chk("mid_grant_a", 32'(obs_ready), 32'h4);
        set_all(0, 4'b0010, 11, 10);
        run_cycle();
        chk("mid_grant_b", 32'(obs_ready), 32'h2);
        set_all(1, 4'b0000, 0, 0);
        run_cycle();
        for (int k = 0; k < 4; k++) begin
            set_all(0, 4'b0000, 0, 0);
            run_cycle();
            chk("mid_no_rsp", 32'(obs_rsp), 32'h0);
        end
        set_all(0, 4'b1111, 12, 12);
        run_cycle();
        chk("mid_ptr_zero", 32'(obs_ready), 32'h1);

        // Back-to-back requests from one requester return in order with the programmed bits.
        set_all(1, 4'b0000, 0, 0);
        run_cycle();
        for (int k = 0; k < 8; k++) begin
            set_all(0, (k < 4) ? 4'b0010 : 4'b0000, 100, 10 + k);
            run_cycle();
            if (k < 4) chk("b2b_grant", 32'(obs_ready), 32'(1 << REQ_ENEMY0));
            if (k >= 3 && k <= 6) begin
                chk("b2b_rsp", 32'(obs_rsp), 32'h2);
                chk("b2b_block", 32'(obs_blk), 32'(bits[k-3]));
            end
        end

        // Randomized traffic obeying the hold-until-ready handshake, with occasional resets.
        set_all(1, 4'b0000, 0, 0);
        run_cycle();
        for (int n = 0; n < 3000; n++) begin
            cur_rst = ($urandom_range(0, 79) == 0);
            run_cycle();
            for (int i = 0; i < 4; i++) begin
                if (!cur_v[i] || obs_ready[i] || cur_rst) begin
                    cur_v[i] = ($urandom_range(0, 3) != 0);
                    cur_x[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(960, 1023) : $urandom_range(0, 959);
                    cur_y[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(500, 1023) : $urandom_range(0, 499);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
